// File: rtl/fifo_stream_reader.sv
// Read-side adapter: pops a registered-output FIFO and presents words as a valid/ready
// stream with frame delimiting, absorbing the FIFO read latency in a 3-entry skid buffer.
module fifo_stream_reader #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_read,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic [LEN_W-1:0] frame_len,
    output logic [31:0]      word_count,
    output logic             busy
);

    logic [1:0]       occ_q, occ_d;
    logic             inflight_q;
    logic [1:0]       head_q, tail_q;
    logic [WIDTH-1:0] buf_q [0:2];
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] frame_len_q, frame_len_d;
    logic [31:0]      word_count_q;
    logic             pop;
    logic [2:0]       reserved;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reserved slots include the word still on its way from the FIFO, so the buffer never
    // overflows even though m_ready has no path to fifo_read.
    always_comb begin
        reserved  = {1'b0, occ_q} + {2'b00, inflight_q};
        fifo_read = rst_n & enable & ~fifo_empty & (reserved < 3'd3);
    end

    always_comb begin
        m_valid    = (occ_q != 2'd0);
        m_data     = buf_q[head_q];
        m_last     = m_valid & (frame_len_q != '0) & (beat_cnt_q == frame_len_q - LEN_W'(1));
        pop        = m_valid & m_ready;
        busy       = m_valid | inflight_q;
        word_count = word_count_q;
    end

    always_comb begin
        occ_d       = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        beat_cnt_d  = beat_cnt_q;
        frame_len_d = frame_len_q;
        if (pop) begin
            if (m_last || (frame_len_q == '0)) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + LEN_W'(1);
            end
        end
        // The frame length is only sampled between frames, never under an accepted beat.
        if ((beat_cnt_q == '0) && !pop) begin
            frame_len_d = frame_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            head_q       <= 2'd0;
            tail_q       <= 2'd0;
            beat_cnt_q   <= '0;
            frame_len_q  <= '0;
            word_count_q <= 32'd0;
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            occ_q       <= occ_d;
            inflight_q  <= fifo_read;
            beat_cnt_q  <= beat_cnt_d;
            frame_len_q <= frame_len_d;
            if (inflight_q) begin
                buf_q[tail_q] <= fifo_data;
                tail_q        <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q       <= ptr_inc(head_q);
                word_count_q <= word_count_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a behavioural registered-output FIFO feeds the DUT,
// a cycle table covers start-up and directed sequences cover stalls, framing, reset and enable.
module tb_fifo_stream_reader;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_read;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic [15:0] frame_len;
    logic [31:0] word_count;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int viol     = 0;

    fifo_stream_reader #(.WIDTH(32), .LEN_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .frame_len  (frame_len),
        .word_count (word_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO with registered data_out
    logic [31:0] mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_read && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && fifo_read && fifo_empty) viol <= viol + 1;
    end

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Collect n unframed beats expected as base, base+1, ...; counts bad words and idle gaps.
    task automatic collect(input int n, input logic [31:0] base, input int max_cyc,
                           output int got, output int bad, output int gaps);
        int first_c;
        int last_c;
        got     = 0;
        bad     = 0;
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < max_cyc && got < n; c++) begin
            #1;
            if (m_valid && m_ready) begin
                if (m_data !== base + 32'(got) || m_last !== 1'b0) bad++;
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            adv();
        end
        gaps = (got == 0) ? 0 : (last_c - first_c + 1 - got);
    endtask

    typedef struct packed {
        logic        exp_rd;
        logic        exp_v;
        logic [31:0] exp_d;
        logic        chk_d;
        logic        exp_l;
        logic [31:0] exp_wc;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int          got, bad, gaps, reads, stable_err;
        logic [31:0] held;
        logic [9:0]  last_mask;
        logic        stall_pending;

        vecs[0] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'd0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 32'h11, 1'b1, 1'b0, 32'd0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b0, 32'd1, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b0, 32'd2, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'd3, 1'b0};

        // Reset with a preloaded FIFO
        rst_n     = 1'b1;
        enable    = 1'b1;
        m_ready   = 1'b1;
        frame_len = 16'd0;
        push(32'h11);
        push(32'h22);
        push(32'h33);
        #1 rst_n = 1'b0;
        #1;
        chk("reset fifo_read", fifo_read, 0);
        chk("reset m_valid", m_valid, 0);
        chk("reset m_data", m_data, 0);
        chk("reset m_last", m_last, 0);
        chk("reset word_count", word_count, 0);
        chk("reset busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("v%0d fifo_read", i), fifo_read, vecs[i].exp_rd);
            chk($sformatf("v%0d m_valid", i), m_valid, vecs[i].exp_v);
            if (vecs[i].chk_d) chk($sformatf("v%0d m_data", i), m_data, vecs[i].exp_d);
            chk($sformatf("v%0d m_last", i), m_last, vecs[i].exp_l);
            chk($sformatf("v%0d word_count", i), word_count, vecs[i].exp_wc);
            chk($sformatf("v%0d busy", i), busy, vecs[i].exp_busy);
            adv();
        end

        // 100 words at full rate
        for (int i = 0; i < 100; i++) push(32'h1000 + 32'(i));
        collect(100, 32'h1000, 300, got, bad, gaps);
        chk("stream100 count", got, 100);
        chk("stream100 order", bad, 0);
        chk("stream100 gaps", gaps, 0);
        chk("stream100 word_count", word_count, 103);
        chk("stream100 read while empty", viol, 0);

        // Backpressure: 10 words, m_ready low
        m_ready    = 1'b0;
        reads      = 0;
        stable_err = 0;
        held       = 32'h0;
        for (int i = 0; i < 10; i++) push(32'h300 + 32'(i));
        for (int c = 0; c < 8; c++) begin
            #1;
            if (fifo_read) reads++;
            if (c == 2) held = m_data;
            else if (c > 2 && m_data !== held) stable_err++;
            adv();
        end
        chk("stall reads", reads, 3);
        chk("stall held data", held, 32'h300);
        chk("stall data stable", stable_err, 0);
        chk("stall busy", busy, 1);
        m_ready = 1'b1;
        #1;
        chk("release first fifo_read", fifo_read, 0);
        chk("release beat0", m_data, 32'h300);
        adv();
        chk("release resume fifo_read", fifo_read, 1);
        chk("release beat1 valid", m_valid, 1);
        chk("release beat1", m_data, 32'h301);
        adv();
        collect(8, 32'h302, 40, got, bad, gaps);
        chk("release count", got, 8);
        chk("release order", bad, 0);
        chk("release gaps", gaps, 0);
        chk("release word_count", word_count, 113);

        // Framing with a length change mid-frame
        frame_len = 16'd4;
        adv();
        adv();
        for (int i = 0; i < 10; i++) push(32'h400 + 32'(i));
        last_mask     = 10'b10_1000_1000;
        stall_pending = 1'b0;
        got           = 0;
        bad           = 0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            m_ready       = !stall_pending;
            stall_pending = 1'b0;
            if (got >= 5) frame_len = 16'd2;
            #1;
            if (m_valid && m_ready) begin
                chk($sformatf("frame beat%0d m_last", got), m_last, last_mask[got]);
                if (m_data !== 32'h400 + 32'(got)) bad++;
                if (got == 7) stall_pending = 1'b1;
                got++;
            end
            adv();
        end
        chk("frame count", got, 10);
        chk("frame order", bad, 0);
        chk("frame word_count", word_count, 123);
        m_ready   = 1'b1;
        frame_len = 16'd0;
        adv();
        adv();

        // Reset with occ=2, inflight=1
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(32'h500 + 32'(i));
        adv();
        adv();
        adv();
        #1;
        chk("prereset fifo_read", fifo_read, 0);
        chk("prereset m_data", m_data, 32'h500);
        chk("prereset busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset fifo_read", fifo_read, 0);
        chk("midreset m_valid", m_valid, 0);
        chk("midreset m_data", m_data, 0);
        chk("midreset m_last", m_last, 0);
        chk("midreset word_count", word_count, 0);
        chk("midreset busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("postreset word_count", word_count, 0);
        chk("postreset fifo_read", fifo_read, 1);
        adv();
        collect(3, 32'h503, 20, got, bad, gaps);
        chk("postreset count", got, 3);
        chk("postreset order", bad, 0);
        chk("postreset word_count end", word_count, 3);

        // Enable dropped with the FIFO still holding words
        for (int i = 0; i < 8; i++) push(32'h600 + 32'(i));
        #1;
        chk("en c0 fifo_read", fifo_read, 1);
        adv();
        adv();
        #1;
        chk("en c2 m_valid", m_valid, 1);
        chk("en c2 m_data", m_data, 32'h600);
        adv();
        enable = 1'b0;
        #1;
        chk("en drop fifo_read", fifo_read, 0);
        chk("en drop m_data", m_data, 32'h601);
        adv();
        chk("en drain m_valid", m_valid, 1);
        chk("en drain m_data", m_data, 32'h602);
        chk("en drain busy", busy, 1);
        adv();
        chk("en idle m_valid", m_valid, 0);
        chk("en idle busy", busy, 0);
        chk("en idle fifo_read", fifo_read, 0);
        chk("en idle word_count", word_count, 6);
        chk("read while empty", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
        $fatal(1);
    end

endmodule
